// File: rtl/puf_ctrl_pkg.sv
// Shared types and byte constants for the PUF main controller.
// Holds the FSM state enums, command/header/error codes and counter sizing.
package puf_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_GET_CHAL,
        ST_PUF_START,
        ST_PUF_WAIT,
        ST_SEND_HDR,
        ST_SEND_ID,
        ST_SEND_RESP,
        ST_SEND_ERR,
        ST_FLUSH
    } state_t;

    typedef enum logic [1:0] {
        R_CHECK,
        R_READ,
        R_LATCH,
        R_SEND
    } resp_phase_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_FREE,
        TX_WAIT_RISE,
        TX_WAIT_FALL
    } tx_state_t;

    localparam logic [7:0] CMD_ID      = 8'h49;
    localparam logic [7:0] CMD_CHAL    = 8'h43;
    localparam logic [7:0] HDR_ID      = 8'hA1;
    localparam logic [7:0] HDR_RESP    = 8'hA2;
    localparam logic [7:0] ERR_CMD     = 8'hE1;
    localparam logic [7:0] ERR_TIMEOUT = 8'hE2;

    // tx_busy must rise within this many cycles of the send pulse
    localparam int TX_GUARD_CYCLES = 4;

    // shared counter: wide enough for a 2^20 cycle PUF timeout
    localparam int CNT_W = 21;

endpackage

// File: rtl/puf_main_controller_tx_byte_sender.sv
// One-byte UART send handshake: wait free, pulse, wait busy rise/fall.
// Ports: start/byte_in launch a byte, done pulses on completion; tx_* to UART.
module tx_byte_sender
    import puf_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic       tx_enable,
    output logic [7:0] tx_data,
    output logic       done
);

    localparam logic [1:0] GUARD_LAST = 2'(TX_GUARD_CYCLES - 1);

    tx_state_t  st;
    logic [1:0] guard;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= TX_IDLE;
            guard     <= '0;
            tx_enable <= 1'b0;
            tx_data   <= '0;
            done      <= 1'b0;
        end else begin
            tx_enable <= 1'b0;
            done      <= 1'b0;
            case (st)
                TX_IDLE: begin
                    if (start) begin
                        tx_data <= byte_in;
                        guard   <= '0;
                        // fire in the launch cycle when the UART is free
                        if (tx_busy) begin
                            st <= TX_WAIT_FREE;
                        end else begin
                            tx_enable <= 1'b1;
                            st        <= TX_WAIT_RISE;
                        end
                    end
                end
                TX_WAIT_FREE: begin
                    if (!tx_busy) begin
                        tx_enable <= 1'b1;
                        guard     <= '0;
                        st        <= TX_WAIT_RISE;
                    end
                end
                TX_WAIT_RISE: begin
                    if (tx_busy) begin
                        st <= TX_WAIT_FALL;
                    end else if (guard == GUARD_LAST) begin
                        // UART never acknowledged: treat as sent
                        done <= 1'b1;
                        st   <= TX_IDLE;
                    end else begin
                        guard <= guard + 2'd1;
                    end
                end
                TX_WAIT_FALL: begin
                    if (!tx_busy) begin
                        done <= 1'b1;
                        st   <= TX_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/puf_main_controller.sv
// PUF main controller: UART command decode, challenge load, PUF run, replies.
// Ports: rx_*/tx_* UART, challenge_* regfile, PUF_*, FIFO_*, id_*, sub-resets, error.
module puf_main_controller
    import puf_ctrl_pkg::*;
#(
    parameter int CHALLENGE_BYTES = 8,
    parameter int ID_BYTES        = 4,
    parameter int MAX_RESP_BYTES  = 64,
    parameter int PUF_TIMEOUT     = 4096,
    parameter int INIT_CYCLES     = 16,
    localparam int CIW = (CHALLENGE_BYTES > 1) ? $clog2(CHALLENGE_BYTES) : 1,
    localparam int IW  = (ID_BYTES > 1) ? $clog2(ID_BYTES) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           rx_enable,
    input  logic           tx_busy,
    output logic           tx_enable,
    output logic [7:0]     tx_data,
    output logic           challenge_we,
    output logic [CIW-1:0] challenge_idx,
    output logic [7:0]     challenge_data,
    output logic           PUF_reset,
    output logic           PUF_enable,
    input  logic           PUF_done,
    input  logic           FIFO_empty,
    output logic           FIFO_re,
    input  logic [7:0]     FIFO_data,
    output logic           FIFO_reset,
    output logic [IW-1:0]  id_idx,
    input  logic [7:0]     id_byte,
    output logic           UART_reset,
    output logic           error
);

    state_t           state;
    resp_phase_t      rphase;
    logic [CNT_W-1:0] cnt;
    logic             hdr_is_id;

    logic       snd_start;
    logic [7:0] snd_byte;
    logic       snd_done;

    logic timeout_hit;
    logic id_last;
    logic resp_stop;

    assign timeout_hit = (cnt == CNT_W'(PUF_TIMEOUT - 1));
    assign id_last     = (cnt == CNT_W'(ID_BYTES));
    assign resp_stop   = (cnt == CNT_W'(MAX_RESP_BYTES)) || FIFO_empty;

    // Launches are combinational so a byte can go out on the same edge
    // the FSM changes state (e.g. header right after PUF_done).
    always_comb begin
        snd_start = 1'b0;
        snd_byte  = 8'h00;
        case (state)
            ST_IDLE: begin
                if (rx_valid && rx_data != CMD_CHAL) begin
                    snd_start = 1'b1;
                    snd_byte  = (rx_data == CMD_ID) ? HDR_ID : ERR_CMD;
                end
            end
            ST_PUF_WAIT: begin
                if (PUF_done) begin
                    snd_start = 1'b1;
                    snd_byte  = HDR_RESP;
                end else if (timeout_hit) begin
                    snd_start = 1'b1;
                    snd_byte  = ERR_TIMEOUT;
                end
            end
            ST_SEND_HDR: begin
                if (snd_done && hdr_is_id) begin
                    snd_start = 1'b1;
                    snd_byte  = id_byte;
                end
            end
            ST_SEND_ID: begin
                if (snd_done && !id_last) begin
                    snd_start = 1'b1;
                    snd_byte  = id_byte;
                end
            end
            ST_SEND_RESP: begin
                if (rphase == R_LATCH) begin
                    snd_start = 1'b1;
                    snd_byte  = FIFO_data;
                end
            end
            default: ;
        endcase
    end

    tx_byte_sender u_sender (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (snd_start),
        .byte_in   (snd_byte),
        .tx_busy   (tx_busy),
        .tx_enable (tx_enable),
        .tx_data   (tx_data),
        .done      (snd_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_INIT;
            rphase         <= R_CHECK;
            cnt            <= '0;
            hdr_is_id      <= 1'b0;
            error          <= 1'b0;
            rx_enable      <= 1'b0;
            challenge_we   <= 1'b0;
            challenge_idx  <= '0;
            challenge_data <= '0;
            PUF_reset      <= 1'b1;
            PUF_enable     <= 1'b0;
            FIFO_re        <= 1'b0;
            FIFO_reset     <= 1'b1;
            UART_reset     <= 1'b1;
            id_idx         <= '0;
        end else begin
            challenge_we <= 1'b0;
            FIFO_re      <= 1'b0;
            PUF_reset    <= 1'b0;
            FIFO_reset   <= 1'b0;
            case (state)
                ST_INIT: begin
                    PUF_reset  <= 1'b1;
                    FIFO_reset <= 1'b1;
                    if (cnt == CNT_W'(INIT_CYCLES)) begin
                        UART_reset <= 1'b0;
                        PUF_reset  <= 1'b0;
                        FIFO_reset <= 1'b0;
                        rx_enable  <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (rx_valid) begin
                        unique case (1'b1)
                            (rx_data == CMD_ID): begin
                                error     <= 1'b0;
                                hdr_is_id <= 1'b1;
                                rx_enable <= 1'b0;
                                state     <= ST_SEND_HDR;
                            end
                            (rx_data == CMD_CHAL): begin
                                error <= 1'b0;
                                cnt   <= '0;
                                state <= ST_GET_CHAL;
                            end
                            default: begin
                                rx_enable <= 1'b0;
                                state     <= ST_SEND_ERR;
                            end
                        endcase
                    end
                end
                ST_GET_CHAL: begin
                    if (rx_valid) begin
                        challenge_we   <= 1'b1;
                        challenge_idx  <= CIW'(cnt);
                        challenge_data <= rx_data;
                        if (cnt == CNT_W'(CHALLENGE_BYTES - 1)) begin
                            rx_enable  <= 1'b0;
                            PUF_reset  <= 1'b1;
                            FIFO_reset <= 1'b1;
                            state      <= ST_PUF_START;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PUF_START: begin
                    PUF_enable <= 1'b1;
                    cnt        <= '0;
                    state      <= ST_PUF_WAIT;
                end
                ST_PUF_WAIT: begin
                    // done on the timeout cycle still wins
                    if (PUF_done) begin
                        PUF_enable <= 1'b0;
                        hdr_is_id  <= 1'b0;
                        state      <= ST_SEND_HDR;
                    end else if (timeout_hit) begin
                        PUF_enable <= 1'b0;
                        state      <= ST_SEND_ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SEND_HDR: begin
                    if (snd_done) begin
                        if (hdr_is_id) begin
                            // byte 0 launched now; point at byte 1
                            cnt <= CNT_W'(1);
                            if (ID_BYTES > 1) begin
                                id_idx <= IW'(1);
                            end
                            state <= ST_SEND_ID;
                        end else begin
                            cnt    <= '0;
                            rphase <= R_CHECK;
                            state  <= ST_SEND_RESP;
                        end
                    end
                end
                ST_SEND_ID: begin
                    if (snd_done) begin
                        if (id_last) begin
                            id_idx    <= '0;
                            rx_enable <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            if (cnt < CNT_W'(ID_BYTES - 1)) begin
                                id_idx <= id_idx + IW'(1);
                            end
                        end
                    end
                end
                ST_SEND_RESP: begin
                    case (rphase)
                        R_CHECK: begin
                            // cap and empty both end with a 1-cycle FIFO reset
                            if (resp_stop) begin
                                FIFO_reset <= 1'b1;
                                state      <= ST_FLUSH;
                            end else begin
                                FIFO_re <= 1'b1;
                                rphase  <= R_READ;
                            end
                        end
                        R_READ: rphase <= R_LATCH;
                        R_LATCH: begin
                            cnt    <= cnt + CNT_W'(1);
                            rphase <= R_SEND;
                        end
                        R_SEND: begin
                            if (snd_done) begin
                                rphase <= R_CHECK;
                            end
                        end
                    endcase
                end
                ST_SEND_ERR: begin
                    if (snd_done) begin
                        error     <= 1'b1;
                        rx_enable <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    rx_enable <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_main_controller.sv
// Directed bench for puf_main_controller with UART, FIFO, ID and regfile models.
// Expected values are hand-computed constants.
module tb_puf_main_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_enable;
    logic       tx_busy = 1'b0;
    logic       tx_enable;
    logic [7:0] tx_data;
    logic       challenge_we;
    logic [2:0] challenge_idx;
    logic [7:0] challenge_data;
    logic       PUF_reset;
    logic       PUF_enable;
    logic       PUF_done = 1'b0;
    logic       FIFO_empty;
    logic       FIFO_re;
    logic [7:0] FIFO_data = 8'h00;
    logic       FIFO_reset;
    logic [1:0] id_idx;
    logic [7:0] id_byte;
    logic       UART_reset;
    logic       error;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] tx_log[$];
    logic       uart_mute = 1'b0;
    int         busy_left = 0;

    logic [7:0] fifo_mem[0:127];
    int rd_ptr = 0;
    int fifo_len = 0;
    int re_cnt = 0;
    int rst_pulses = 0;

    logic [7:0] chal_mem[0:7];
    int chal_writes = 0;

    always #5 clk = ~clk;

    puf_main_controller #(
        .CHALLENGE_BYTES (8),
        .ID_BYTES        (4),
        .MAX_RESP_BYTES  (64),
        .PUF_TIMEOUT     (32),
        .INIT_CYCLES     (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_enable      (rx_enable),
        .tx_busy        (tx_busy),
        .tx_enable      (tx_enable),
        .tx_data        (tx_data),
        .challenge_we   (challenge_we),
        .challenge_idx  (challenge_idx),
        .challenge_data (challenge_data),
        .PUF_reset      (PUF_reset),
        .PUF_enable     (PUF_enable),
        .PUF_done       (PUF_done),
        .FIFO_empty     (FIFO_empty),
        .FIFO_re        (FIFO_re),
        .FIFO_data      (FIFO_data),
        .FIFO_reset     (FIFO_reset),
        .id_idx         (id_idx),
        .id_byte        (id_byte),
        .UART_reset     (UART_reset),
        .error          (error)
    );

    assign id_byte    = 8'h10 + {6'b0, id_idx};
    assign FIFO_empty = (rd_ptr >= fifo_len);

    // UART: busy for 4 cycles after each accepted byte, unless muted
    always @(posedge clk) begin
        if (tx_enable) begin
            tx_log.push_back(tx_data);
            if (!uart_mute) begin
                tx_busy   <= 1'b1;
                busy_left = 4;
            end
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) tx_busy <= 1'b0;
        end
    end

    // response FIFO: registered read data
    always @(posedge clk) begin
        if (FIFO_reset) begin
            rd_ptr = 0;
            fifo_len = 0;
            rst_pulses++;
        end else if (FIFO_re) begin
            FIFO_data <= fifo_mem[rd_ptr];
            rd_ptr++;
            re_cnt++;
        end
    end

    always @(posedge clk) begin
        if (challenge_we) begin
            chal_mem[challenge_idx] = challenge_data;
            chal_writes++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!rx_enable && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, rx_enable, 1);
    endtask

    task automatic send_challenge();
        send_rx(8'h43);
        for (int i = 0; i < 8; i++) send_rx(8'h30 + 8'(i));
    endtask

    task automatic load_fifo(input int n);
        for (int i = 0; i < n; i++) fifo_mem[i] = 8'(i * 3 + 1);
        rd_ptr = 0;
        fifo_len = n;
        re_cnt = 0;
        rst_pulses = 0;
    endtask

    logic [7:0] exp_id[5] = '{8'hA1, 8'h10, 8'h11, 8'h12, 8'h13};

    initial begin
        int hi;
        int en;
        int errs;
        int n;
        int snap;

        #12;
        check("rst_resets", {UART_reset, PUF_reset, FIFO_reset}, 3'b111);
        check("rst_zero", {rx_enable, tx_enable, tx_data, challenge_we,
              challenge_idx, challenge_data, PUF_enable, FIFO_re,
              id_idx, error}, 0);

        @(negedge clk);
        reset_n = 1'b1;
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!UART_reset) break;
            hi++;
        end
        check("init_cycles", hi, 16);
        check("init_rx_en", rx_enable, 1);
        check("init_sub_rst", {PUF_reset, FIFO_reset}, 0);

        // device ID
        tx_log.delete();
        send_rx(8'h49);
        wait_idle("id", 200);
        check("id_len", tx_log.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("id_b%0d", i), tx_log[i], exp_id[i]);
        check("id_err", error, 0);

        // bad command, then clear
        tx_log.delete();
        send_rx(8'h55);
        wait_idle("bad", 200);
        check("bad_len", tx_log.size(), 1);
        check("bad_byte", tx_log[0], 8'hE1);
        check("bad_err", error, 1);
        send_rx(8'h49);
        check("err_clear", error, 0);
        wait_idle("id2", 200);

        // challenge + PUF done after 5 cycles, 4 FIFO bytes
        tx_log.delete();
        chal_writes = 0;
        send_challenge();
        check("chal_puf_rst", PUF_reset, 1);
        check("chal_fifo_rst", FIFO_reset, 1);
        @(negedge clk);
        check("puf_en_rise", {PUF_enable, PUF_reset}, 2'b10);
        load_fifo(4);
        repeat (4) @(negedge clk);
        PUF_done = 1'b1;
        @(negedge clk);
        PUF_done = 1'b0;
        check("done_en_drop", PUF_enable, 0);
        check("hdr_pulse", tx_enable, 1);
        check("hdr_byte", tx_data, 8'hA2);
        wait_idle("resp", 400);
        check("resp_len", tx_log.size(), 5);
        check("resp_hdr", tx_log[0], 8'hA2);
        for (int i = 0; i < 4; i++)
            check($sformatf("resp_b%0d", i), tx_log[i+1], 8'(i * 3 + 1));
        check("resp_re", re_cnt, 4);
        check("resp_frst", rst_pulses, 1);
        check("chal_writes", chal_writes, 8);
        check("chal_0", chal_mem[0], 8'h30);
        check("chal_7", chal_mem[7], 8'h37);

        // timeout
        tx_log.delete();
        send_challenge();
        @(negedge clk);
        en = 0;
        while (PUF_enable && en < 100) begin
            en++;
            @(negedge clk);
        end
        check("timeout_len", en, 32);
        wait_idle("tmo", 200);
        check("tmo_len", tx_log.size(), 1);
        check("tmo_byte", tx_log[0], 8'hE2);
        check("tmo_err", error, 1);

        // done on the timeout cycle wins; empty FIFO -> header only
        tx_log.delete();
        send_challenge();
        check("chal_clr_err", error, 0);
        @(negedge clk);
        repeat (31) @(negedge clk);
        PUF_done = 1'b1;
        @(negedge clk);
        PUF_done = 1'b0;
        check("edge_hdr", {tx_enable, tx_data}, {1'b1, 8'hA2});
        wait_idle("edge", 200);
        check("edge_len", tx_log.size(), 1);
        check("edge_err", error, 0);

        // cap at 64 of 70 bytes
        tx_log.delete();
        send_challenge();
        @(negedge clk);
        load_fifo(70);
        @(negedge clk);
        PUF_done = 1'b1;
        @(negedge clk);
        PUF_done = 1'b0;
        wait_idle("cap", 3000);
        check("cap_len", tx_log.size(), 65);
        errs = 0;
        for (int i = 0; i < 64; i++)
            if (tx_log[i+1] !== 8'(i * 3 + 1)) errs++;
        check("cap_payload", errs, 0);
        check("cap_re", re_cnt, 64);
        check("cap_flush", rst_pulses, 1);

        // UART never raises busy: guard completes each byte
        uart_mute = 1'b1;
        tx_log.delete();
        send_rx(8'h49);
        wait_idle("mute", 200);
        check("mute_len", tx_log.size(), 5);
        check("mute_last", tx_log[4], 8'h13);
        uart_mute = 1'b0;

        // async reset in the middle of SEND_RESP
        tx_log.delete();
        send_challenge();
        @(negedge clk);
        load_fifo(10);
        @(negedge clk);
        PUF_done = 1'b1;
        @(negedge clk);
        PUF_done = 1'b0;
        n = 0;
        while (tx_log.size() < 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("mid_progress", tx_log.size() >= 3, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_resets", {UART_reset, PUF_reset, FIFO_reset}, 3'b111);
        check("mid_zero", {rx_enable, tx_enable, tx_data, challenge_we,
              challenge_idx, challenge_data, PUF_enable, FIFO_re,
              id_idx, error}, 0);
        snap = tx_log.size();
        @(negedge clk);
        reset_n = 1'b1;
        wait_idle("reinit", 100);
        check("no_resend", tx_log.size(), snap);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
